// File: rtl/automata_engine_prog.sv
// Runtime-programmable homogeneous NFA engine. Every STE updates in parallel once per symbol.
// Reports are tagged with their symbol offset and queued in a small FIFO.
module automata_ste #(
    parameter int N_STE = 16,
    parameter int SYM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_sel,
    input  logic [1:0]       cfg_type,
    input  logic [SYM_W-1:0] cfg_addr,
    input  logic [N_STE-1:0] cfg_wdata,
    input  logic [SYM_W-1:0] symbols,
    input  logic             first,
    input  logic [N_STE-1:0] active_vector,
    output logic             next_active,
    output logic             rep
);
    logic [2**SYM_W-1:0] match_tbl;
    logic [N_STE-1:0]    edge_row;
    logic [1:0]          start;
    logic                enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            match_tbl <= '0;
            edge_row  <= '0;
            start     <= '0;
            rep       <= 1'b0;
        end else if (cfg_sel) begin
            case (cfg_type)
                2'd0:    match_tbl[cfg_addr] <= cfg_wdata[0];
                2'd1:    edge_row            <= cfg_wdata;
                2'd2:    start               <= cfg_wdata[1:0];
                default: rep                 <= cfg_wdata[0];
            endcase
        end
    end

    // start code 3 enables nothing, same as "none"
    assign enable      = (|(edge_row & active_vector)) | (start == 2'd2) | ((start == 2'd1) & first);
    assign next_active = match_tbl[symbols] & enable;
endmodule

module automata_engine_prog #(
    parameter int N_STE      = 16,
    parameter int SYM_W      = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int OFF_W      = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [SYM_W-1:0]         symbols,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_type,
    input  logic [$clog2(N_STE)-1:0] cfg_ste,
    input  logic [SYM_W-1:0]         cfg_addr,
    input  logic [N_STE-1:0]         cfg_wdata,
    output logic [N_STE-1:0]         active_vector,
    output logic                     report_valid,
    input  logic                     report_ready,
    output logic [OFF_W-1:0]         report_offset,
    output logic [N_STE-1:0]         report_vector,
    output logic                     overflow
);
    localparam int STE_W = $clog2(N_STE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [N_STE-1:0] next_vec, rep_vec, hit;
    logic             first;
    logic [OFF_W-1:0] offset;
    logic             cfg_ok;

    assign cfg_ok = cfg_we & ~run;

    for (genvar g = 0; g < N_STE; g++) begin : g_ste
        automata_ste #(.N_STE(N_STE), .SYM_W(SYM_W)) u_ste (
            .clk          (clk),
            .reset        (reset),
            .cfg_sel      (cfg_ok && (cfg_ste == STE_W'(g))),
            .cfg_type     (cfg_type),
            .cfg_addr     (cfg_addr),
            .cfg_wdata    (cfg_wdata),
            .symbols      (symbols),
            .first        (first),
            .active_vector(active_vector),
            .next_active  (next_vec[g]),
            .rep          (rep_vec[g])
        );
    end

    assign hit = next_vec & rep_vec;

    logic [FIFO_DEPTH-1:0][OFF_W-1:0] fifo_off;
    logic [FIFO_DEPTH-1:0][N_STE-1:0] fifo_vec;
    logic [PTR_W:0]                   wr_ptr, rd_ptr, count;
    logic [PTR_W-1:0]                 head_idx;
    logic                             full, push, pop, wr_en;

    assign count        = wr_ptr - rd_ptr;
    assign full         = count == (PTR_W+1)'(FIFO_DEPTH);
    assign report_valid = count != '0;
    assign push         = run & (|hit);
    assign pop          = report_valid & report_ready;
    assign wr_en        = push & (~full | pop);
    // When empty, keep showing the slot behind rd_ptr: the last entry popped (or zero after reset).
    assign head_idx      = report_valid ? rd_ptr[PTR_W-1:0] : rd_ptr[PTR_W-1:0] - PTR_W'(1);
    assign report_offset = fifo_off[head_idx];
    assign report_vector = fifo_vec[head_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            active_vector <= '0;
            offset        <= '0;
            first         <= 1'b1;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            overflow      <= 1'b0;
            fifo_off      <= '0;
            fifo_vec      <= '0;
        end else begin
            if (run) begin
                active_vector <= next_vec;
                offset        <= offset + OFF_W'(1);
                first         <= 1'b0;
            end
            if (wr_en) begin
                fifo_off[wr_ptr[PTR_W-1:0]] <= offset;
                fifo_vec[wr_ptr[PTR_W-1:0]] <= hit;
                wr_ptr                      <= wr_ptr + (PTR_W+1)'(1);
            end else if (push) begin
                overflow <= 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end
endmodule

// File: tb/tb_automata_engine_prog.sv
// Bench for automata_engine_prog: directed test-plan scenarios plus a randomized phase, all against a set/queue model.
module tb_automata_engine_prog;
    localparam int N  = 16;
    localparam int SW = 8;
    localparam int D  = 8;
    localparam int OW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1, run = 1'b0, cfg_we = 1'b0, report_ready = 1'b0;
    logic [SW-1:0] symbols = '0, cfg_addr = '0;
    logic [1:0]    cfg_type = '0;
    logic [3:0]    cfg_ste = '0;
    logic [N-1:0]  cfg_wdata = '0;
    logic [N-1:0]  active_vector, report_vector;
    logic          report_valid, overflow;
    logic [OW-1:0] report_offset;

    automata_engine_prog #(.N_STE(N), .SYM_W(SW), .FIFO_DEPTH(D), .OFF_W(OW)) dut (
        .clk(clk), .reset(reset), .run(run), .symbols(symbols),
        .cfg_we(cfg_we), .cfg_type(cfg_type), .cfg_ste(cfg_ste), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .active_vector(active_vector), .report_valid(report_valid),
        .report_ready(report_ready), .report_offset(report_offset),
        .report_vector(report_vector), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0;

    // Reference model: configuration as plain arrays, reports as a queue of {offset, vector}.
    bit               m_match [N][256];
    logic [N-1:0]     m_edge  [N];
    int               m_start [N];
    bit               m_rep   [N];
    logic [N-1:0]     m_act;
    bit               m_first, m_ovf;
    logic [OW-1:0]    m_off;
    logic [OW+N-1:0]  m_q[$];
    logic [OW+N-1:0]  m_last;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            for (int s = 0; s < 256; s++) m_match[i][s] = 1'b0;
            m_edge[i] = '0; m_start[i] = 0; m_rep[i] = 1'b0;
        end
        m_act = '0; m_first = 1'b1; m_ovf = 1'b0; m_off = '0; m_last = '0;
        m_q.delete();
    endtask

    task automatic model_edge(bit rst, bit we, int ty, int ste, int addr, int wd, bit r, int sym, bit rdy);
        logic [N-1:0] nxt, hit;
        bit en, valid;
        if (rst) begin
            model_reset();
            return;
        end
        valid = m_q.size() != 0;
        if (we && !r) begin
            case (ty)
                0: m_match[ste][addr] = wd[0];
                1: m_edge[ste] = wd[N-1:0];
                2: m_start[ste] = wd & 3;
                default: m_rep[ste] = wd[0];
            endcase
        end
        if (valid && rdy) m_last = m_q.pop_front();
        if (r) begin
            nxt = '0; hit = '0;
            for (int i = 0; i < N; i++) begin
                en = 1'b0;
                for (int j = 0; j < N; j++) if (m_edge[i][j] && m_act[j]) en = 1'b1;
                if (m_start[i] == 2 || (m_start[i] == 1 && m_first)) en = 1'b1;
                nxt[i] = m_match[i][sym] && en;
                hit[i] = nxt[i] && m_rep[i];
            end
            if (hit != 0) begin
                if (m_q.size() < D) m_q.push_back({m_off, hit});
                else m_ovf = 1'b1;
            end
            m_act = nxt; m_off = m_off + 1; m_first = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic [OW+N-1:0] head;
        head = (m_q.size() != 0) ? m_q[0] : m_last;
        check("active_vector", 64'(active_vector), 64'(m_act));
        check("report_valid",  64'(report_valid),  64'(m_q.size() != 0));
        check("report_offset", 64'(report_offset), 64'(head[OW+N-1:N]));
        check("report_vector", 64'(report_vector), 64'(head[N-1:0]));
        check("overflow",      64'(overflow),      64'(m_ovf));
    endtask

    task automatic cyc(bit rst, bit we, int ty, int ste, int addr, int wd, bit r, int sym, bit rdy);
        @(negedge clk);
        reset = rst; cfg_we = we; cfg_type = ty[1:0]; cfg_ste = ste[3:0];
        cfg_addr = addr[SW-1:0]; cfg_wdata = wd[N-1:0]; run = r; symbols = sym[SW-1:0];
        report_ready = rdy;
        @(posedge clk);
        model_edge(rst, we, ty, ste, addr, wd, r, sym, rdy);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(int ty, int ste, int addr, int wd);
        cyc(0, 1, ty, ste, addr, wd, 0, 0, 0);
    endtask

    task automatic sym_step(int sym, bit rdy);
        cyc(0, 0, 0, 0, 0, 0, 1, sym, rdy);
    endtask

    task automatic program_base(int st0);
        cfg(0, 0, 4, 1); cfg(2, 0, 0, st0);
        cfg(0, 1, 60, 1); cfg(0, 1, 62, 1); cfg(0, 1, 97, 1); cfg(0, 1, 110, 1); cfg(0, 1, 121, 1);
        cfg(1, 1, 0, 'h1);
        for (int s = 0; s < 256; s++) if (s != 4) cfg(0, 2, s, 1);
        cfg(1, 2, 0, 'h6);
        cfg(0, 3, 38, 1); cfg(0, 3, 59, 1); cfg(0, 3, 96, 1); cfg(0, 3, 124, 1);
        cfg(1, 3, 0, 'h6); cfg(3, 3, 0, 1);
    endtask

    initial begin
        model_reset();
        do_reset(); do_reset();
        check("rst_valid", 64'(report_valid), 0);
        check("rst_offset", 64'(report_offset), 0);

        // chain 0 -> 1 -> 3 reports at offset 2
        program_base(2);
        sym_step(4, 0); sym_step(97, 0); sym_step(38, 0);
        check("t1_valid", 64'(report_valid), 1);
        check("t1_offset", 64'(report_offset), 2);
        check("t1_vector", 64'(report_vector), 'h8);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("t1_drained", 64'(report_valid), 0);
        check("t1_hold_off", 64'(report_offset), 2);

        // longer chain through self-looping STE2 into STE4/STE5
        do_reset();
        program_base(2);
        cfg(0, 4, 36, 1); cfg(0, 4, 60, 1); cfg(0, 4, 62, 1); cfg(1, 4, 0, 'h6);
        cfg(0, 5, 40, 1); cfg(1, 5, 0, 'h10); cfg(3, 5, 0, 1);
        sym_step(4, 0); sym_step(60, 0);
        sym_step(7, 0);  check("t2_ste2_o2", 64'(active_vector[2]), 1);
        sym_step(36, 0); check("t2_ste2_o3", 64'(active_vector[2]), 1);
        sym_step(40, 0);
        check("t2_offset", 64'(report_offset), 4);
        check("t2_vector", 64'(report_vector), 'h20);

        // start-of-data only: second 4 breaks the chain
        do_reset();
        program_base(1);
        sym_step(4, 0); check("t3_ste0", 64'(active_vector), 1);
        sym_step(4, 0); sym_step(97, 0); sym_step(38, 0);
        check("t3_noreport", 64'(report_valid), 0);

        // overflow: ten hits into an 8-deep FIFO, then drain in order
        do_reset();
        cfg(0, 0, 4, 1); cfg(2, 0, 0, 2); cfg(3, 0, 0, 1);
        for (int k = 0; k < 10; k++) sym_step(4, 0);
        check("t4_overflow", 64'(overflow), 1);
        for (int k = 0; k < D; k++) begin
            check("t4_head", 64'(report_offset), 64'(k));
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        end
        check("t4_empty", 64'(report_valid), 0);

        // full FIFO with simultaneous push and pop
        do_reset();
        cfg(0, 0, 4, 1); cfg(2, 0, 0, 2); cfg(3, 0, 0, 1);
        for (int k = 0; k < D; k++) sym_step(4, 0);
        sym_step(4, 1);
        check("t5_no_ovf", 64'(overflow), 0);
        for (int k = 0; k < D; k++) begin
            check("t5_valid", 64'(report_valid), 1);
            check("t5_head", 64'(report_offset), 64'(k + 1));
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        end
        check("t5_empty", 64'(report_valid), 0);

        // reset mid-stream swallows a pending config write
        do_reset();
        program_base(1);
        sym_step(4, 0);
        cyc(1, 1, 3, 0, 0, 1, 0, 0, 0);
        check("t6_act", 64'(active_vector), 0);
        check("t6_valid", 64'(report_valid), 0);
        check("t6_vector", 64'(report_vector), 0);
        check("t6_ovf", 64'(overflow), 0);
        cfg(0, 0, 4, 1); cfg(2, 0, 0, 1);
        sym_step(4, 0);
        check("t6_first", 64'(active_vector), 1);
        check("t6_rep_ignored", 64'(report_valid), 0);

        // randomized programming/streaming over a small alphabet
        do_reset();
        for (int k = 0; k < 800; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r == 0)
                cyc(1, $urandom_range(0, 1), 0, 0, 0, 0, 0, 0, 0);
            else if (r < 35)
                cyc(0, 1, $urandom_range(0, 3), $urandom_range(0, N - 1), $urandom_range(0, 7),
                    int'($urandom & 32'hffff), $urandom_range(0, 9) == 0, $urandom_range(0, 7),
                    $urandom_range(0, 1));
            else
                cyc(0, 0, 0, 0, 0, 0, $urandom_range(0, 4) != 0, $urandom_range(0, 7),
                    $urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/automata_engine_prog.md
Name: automata_engine_prog

Overview:
- Runtime-programmable homogeneous NFA engine. Generalises the fixed, generator-emitted Automata_* blocks: STE count is a parameter, and match sets, edges, start types and report flags are loaded through a config port instead of being hard-coded.
- Consumes one symbol per run cycle and updates all STE active states in parallel.
- Each report is tagged with the symbol offset and the report-STE vector, then queued in a report FIFO for the host/DMA side of the kernel.

Parameters:
- N_STE, 16, number of STEs (2..64).
- SYM_W, 8, symbol width; each STE match table holds 2^SYM_W bits.
- FIFO_DEPTH, 8, report FIFO entries (power of 2, >=2).
- OFF_W, 32, symbol offset counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  consume `symbols` this cycle.
- symbols  in  SYM_W  input symbol.
- cfg_we  in  1  config write strobe.
- cfg_type  in  2  0=match bit, 1=edge row, 2=start type, 3=report flag.
- cfg_ste  in  clog2(N_STE)  target STE index.
- cfg_addr  in  SYM_W  symbol value (type 0 only).
- cfg_wdata  in  N_STE  write data (see Behaviour).
- active_vector  out  N_STE  registered STE active states.
- report_valid  out  1  FIFO head valid.
- report_ready  in  1  consumer accepts head.
- report_offset  out  OFF_W  offset of the symbol that produced the report.
- report_vector  out  N_STE  reporting STEs active at that offset.
- overflow  out  1  sticky: a report was dropped.

Behaviour:
- Reset (clk edge with reset=1) clears:
  - all match tables, edge rows, start types and report flags;
  - active_vector and the offset counter;
  - FIFO pointers and overflow;
  - the first-symbol flag, which is set to 1.
  - Outputs after reset: active_vector=0, report_valid=0, overflow=0, report_offset=0, report_vector=0.
- Config writes:
  - Accepted only when cfg_we=1, run=0 and reset=0. Otherwise ignored, with no error flag.
  - Type 0: match[cfg_ste][cfg_addr] = cfg_wdata[0].
  - Type 1: edge[cfg_ste] = cfg_wdata. Bit j set means STE j feeds cfg_ste; self-loops are allowed.
  - Type 2: start[cfg_ste] = cfg_wdata[1:0]. 0=none, 1=start-of-data, 2=all-input, 3 is treated as 0.
  - Type 3: rep[cfg_ste] = cfg_wdata[0].
  - Written values take effect on the next run cycle.
- Symbol step, on a cycle with run=1:
  - enable_i = (|(edge[i] & active_vector)) | (start[i]==2) | (start[i]==1 & first).
  - active_vector[i] <= match[i][symbols] & enable_i.
  - first <= 0.
  - The offset counter increments and wraps at 2^OFF_W.
  - A run=0 cycle holds active_vector, the counter and first unchanged.
- Report generation:
  - Combinational from the same-cycle next state: hit = next_active & rep.
  - If run=1 and hit!=0, push {offset_before_increment, hit}. The push lands in the FIFO at the same edge, so report_valid can rise 1 cycle after the symbol is presented.
  - One push maximum per symbol.
- FIFO behaviour:
  - Standard valid/ready: pop on report_valid & report_ready.
  - report_offset and report_vector hold stable while valid and not popped.
  - Full with a push and no pop in the same cycle: the new report is dropped and overflow<=1. Overflow stays set until reset.
  - Full with both push and pop in the same cycle: both occur, count is unchanged, no overflow.
  - Empty: report_valid=0, and report_offset/report_vector hold their last values.
  - FIFO draining continues while run=0.
- Reset mid-stream discards queued reports and all programming. The host must reprogram before resuming.
- Throughput: 1 symbol/clk. No backpressure on run; loss is signalled only via overflow.

Test Plan:
1. Program STE0 = {4} with start=2; STE1 = {60,62,97,110,121} fed by 0; STE2 = {0..3,5..255} fed by {1,2}; STE3 = {38,59,96,124} fed by {1,2}, rep=1. Stream 4,97,38 -> one report with offset=2, vector=0x8.
2. Same program plus STE4 = {36,60,62} fed by {1,2}; STE5 = {40} fed by 4, rep=1. Stream 4,60,7,36,40 -> one report with offset=4, vector=0x20; active_vector bit2 stays set through offsets 2..3.
3. Set STE0 start=1. Stream 4,4,97,38 -> no report, since STE0 is active only at offset 0 and the chain breaks at the second 4.
4. FIFO_DEPTH=8, report_ready=0, STE0 = {4} start=2 rep=1. Stream ten 4s -> 8 entries with offsets 0..7, overflow=1. Then pop all -> offsets 0..7 in order, report_valid=0.
5. Full FIFO with report_ready=1 and run=1 making a hit -> push and pop in the same cycle, no overflow, count stays 8.
6. Assert reset for 1 cycle mid-stream with cfg_we=1 and run=0 pending -> all outputs 0, config write ignored. After reprogramming, the first symbol again satisfies start=1.
